// File: rtl/cvp14_mem_responder.sv
// cvp14_mem_responder: memory-side responder for the CVP14 core bus.
// A single word-addressed 16-bit array serves core reads (fixed pipelined
// latency) and writes, plus a valid/ready preload port that can run while
// the core is held in reset. Saturating access counters and sticky status
// flags are provided for verification.
module cvp14_mem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_v,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        err_oob,
  output logic        err_rdwr,
  output logic        ovf_seen
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Time-zero contents only; Reset never touches the array.
  logic [15:0] mem [0:DEPTH-1] = '{default: ((INIT_ZERO != 0) ? 16'h0000 : 16'hxxxx)};

  // Read pipeline: stage index i holds the request captured i edges ago.
  logic        vld_p  [READ_LAT];
  logic [15:0] addr_p [READ_LAT];

  logic        rd_accept;
  logic        wr_accept;
  logic        ld_fire;
  logic        cpu_in_range;
  logic        ld_in_range;
  logic        last_in_range;
  logic [15:0] last_addr;
  logic [15:0] rd_word;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  function automatic logic addr_in_range(input logic [15:0] a);
    return (a >> DEPTH_LOG2) == 16'd0;
  endfunction

  // A collision is a write only; the core is ignored while Reset is high.
  assign rd_accept     = cpu_rd & ~cpu_wr & ~Reset;
  assign wr_accept     = cpu_wr & ~Reset;
  assign ld_ready      = ~cpu_rd & ~cpu_wr;
  assign ld_fire       = ld_valid & ld_ready;
  assign cpu_in_range  = addr_in_range(cpu_addr);
  assign ld_in_range   = addr_in_range(ld_addr);
  assign last_addr     = addr_p[READ_LAT-1];
  assign last_in_range = addr_in_range(last_addr);

  // Array is read at the final stage so in-flight reads see later writes.
  assign rd_word = last_in_range ? mem[last_addr[DEPTH_LOG2-1:0]] : 16'h0000;

  // Single write port: the core has priority, preload only when ready.
  always_ff @(posedge Clk1) begin
    if (wr_accept && cpu_in_range)
      mem[cpu_addr[DEPTH_LOG2-1:0]] <= cpu_wdata;
    else if (ld_fire && ld_in_range)
      mem[ld_addr[DEPTH_LOG2-1:0]] <= ld_data;
  end

  // Stage valids shift every cycle with no stall; Reset drops in-flight reads.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_accept;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage addresses shift alongside the valids; no reset needed.
  always_ff @(posedge Clk1) begin
    addr_p[0] <= cpu_addr;
    for (int i = 1; i < READ_LAT; i++) addr_p[i] <= addr_p[i-1];
  end

  // ---- response stage: rd_data holds until the next read completes ----
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      rd_data  <= 16'h0000;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= vld_p[READ_LAT-1];
      if (vld_p[READ_LAT-1]) rd_data <= rd_word;
    end
  end

  // Saturating access counters.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else begin
      if (rd_accept) rd_count <= sat_inc(rd_count);
      if (wr_accept) wr_count <= sat_inc(wr_count);
    end
  end

  // Sticky status flags, cleared only by Reset.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      err_oob  <= 1'b0;
      err_rdwr <= 1'b0;
      ovf_seen <= 1'b0;
    end else begin
      if (((rd_accept | wr_accept) & ~cpu_in_range) | (ld_fire & ~ld_in_range))
        err_oob <= 1'b1;
      if (cpu_rd & cpu_wr) err_rdwr <= 1'b1;
      if (cpu_v) ovf_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Directed testbench for cvp14_mem_responder. Three instances (read latency
// 1, 2 and 3) share the same stimulus so latency-dependent behaviour can be
// checked side by side.
module tb_cvp14_mem_responder;

  logic        Clk1 = 1'b0;
  logic        Reset;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_wdata;
  logic        cpu_v;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  logic [15:0] rd_data1, rd_data2, rd_data3;
  logic        rd_valid1, rd_valid2, rd_valid3;
  logic        ld_ready1, ld_ready2, ld_ready3;
  logic [15:0] rd_count1, rd_count2, rd_count3;
  logic [15:0] wr_count1, wr_count2, wr_count3;
  logic        err_oob1, err_oob2, err_oob3;
  logic        err_rdwr1, err_rdwr2, err_rdwr3;
  logic        ovf_seen1, ovf_seen2, ovf_seen3;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk1 = ~Clk1;

  cvp14_mem_responder #(.DEPTH_LOG2(12), .READ_LAT(1), .INIT_ZERO(1)) dut_l1 (
    .Clk1(Clk1), .Reset(Reset), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_v(cpu_v), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .ld_valid(ld_valid), .ld_ready(ld_ready1), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_count(rd_count1), .wr_count(wr_count1), .err_oob(err_oob1),
    .err_rdwr(err_rdwr1), .ovf_seen(ovf_seen1));

  cvp14_mem_responder #(.DEPTH_LOG2(12), .READ_LAT(2), .INIT_ZERO(1)) dut_l2 (
    .Clk1(Clk1), .Reset(Reset), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_v(cpu_v), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_count(rd_count2), .wr_count(wr_count2), .err_oob(err_oob2),
    .err_rdwr(err_rdwr2), .ovf_seen(ovf_seen2));

  cvp14_mem_responder #(.DEPTH_LOG2(12), .READ_LAT(3), .INIT_ZERO(1)) dut_l3 (
    .Clk1(Clk1), .Reset(Reset), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_v(cpu_v), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .ld_valid(ld_valid), .ld_ready(ld_ready3), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_count(rd_count3), .wr_count(wr_count3), .err_oob(err_oob3),
    .err_rdwr(err_rdwr3), .ovf_seen(ovf_seen3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    #1;
    check("ld_ready_preload", ld_ready1, 1);
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
    cpu_v = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();

    // Reset state
    check("rst_rd_data",  rd_data1, 0);
    check("rst_rd_valid", rd_valid1, 0);
    check("rst_rd_count", rd_count1, 0);
    check("rst_wr_count", wr_count1, 0);
    check("rst_err_oob",  err_oob1, 0);
    check("rst_err_rdwr", err_rdwr1, 0);
    check("rst_ovf_seen", ovf_seen1, 0);

    // Preload while Reset is held
    preload(16'h0000, 16'h8123);
    preload(16'h0001, 16'hABCD);
    for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), 16'(i + 1));
    Reset = 1'b0;
    tick();

    // Single read, latency 1
    cpu_rd = 1'b1; cpu_addr = 16'h0000;
    #1;
    check("ld_ready_busy", ld_ready1, 0);
    tick();
    check("rd0_not_yet", rd_valid1, 0);
    cpu_rd = 1'b0;
    tick();
    check("rd0_data",  rd_data1, 16'h8123);
    check("rd0_valid", rd_valid1, 1);
    check("rd0_count", rd_count1, 1);

    // Burst read 0x10..0x13
    for (int i = 0; i < 4; i++) begin
      cpu_rd = 1'b1; cpu_addr = 16'h0010 + 16'(i);
      tick();
      if (i > 0) begin
        check("burst_data", rd_data1, 32'(i));
        check("burst_valid", rd_valid1, 1);
      end
    end
    cpu_rd = 1'b0;
    tick();
    check("burst_data_last", rd_data1, 4);
    check("burst_valid_last", rd_valid1, 1);
    tick();
    check("burst_valid_drop", rd_valid1, 0);
    check("burst_data_hold", rd_data1, 4);

    // Write then read next cycle
    cpu_wr = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h3C00;
    tick();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    tick();
    check("raw_wr_count", wr_count1, 1);
    cpu_rd = 1'b0;
    tick();
    check("raw_l1_data", rd_data1, 16'h3C00);
    tick();
    tick();
    check("raw_l3_data",  rd_data3, 16'h3C00);
    check("raw_l3_valid", rd_valid3, 1);

    // Write lands while a read of the same address is in flight
    cpu_rd = 1'b1; cpu_addr = 16'h0021;
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_wdata = 16'h7777;
    tick();
    check("flight_l1_old", rd_data1, 16'h0000);
    cpu_wr = 1'b0;
    tick();
    check("flight_l2_new", rd_data2, 16'h7777);
    tick();
    check("flight_l3_new", rd_data3, 16'h7777);

    // Read/write collision
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h0055;
    tick();
    check("coll_err_rdwr", err_rdwr1, 1);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick();
    check("coll_no_valid", rd_valid1, 0);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    tick();
    check("coll_readback", rd_data1, 16'h0055);

    // Out-of-range read
    cpu_rd = 1'b1; cpu_addr = 16'h1000;
    tick();
    check("oob_err_early", err_oob1, 1);
    cpu_rd = 1'b0;
    tick();
    check("oob_data",  rd_data1, 16'h0000);
    check("oob_valid", rd_valid1, 1);
    check("cnt_rd", rd_count1, 9);
    check("cnt_wr", wr_count1, 3);

    // Overflow flag
    cpu_v = 1'b1;
    tick();
    cpu_v = 1'b0;
    tick(); tick();
    check("ovf_sticky", ovf_seen1, 1);

    // Reset one cycle after a read (latency 2)
    cpu_rd = 1'b1; cpu_addr = 16'h0020;
    tick();
    cpu_rd = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check("rstmid_valid",  rd_valid2, 0);
    check("rstmid_rd_cnt", rd_count2, 0);
    check("rstmid_wr_cnt", wr_count2, 0);
    check("rstmid_oob",    err_oob2, 0);
    check("rstmid_rdwr",   err_rdwr2, 0);
    check("rstmid_ovf",    ovf_seen2, 0);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    tick();
    check("rstmid_l2_wait", rd_valid2, 0);
    tick();
    check("rstmid_keep_data", rd_data2, 16'h3C00);
    check("rstmid_keep_valid", rd_valid2, 1);

    // Counter saturation
    Reset = 1'b1;
    tick();
    Reset = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h0000;
    repeat (65534) tick();
    check("sat_fffe", rd_count1, 16'hFFFE);
    tick();
    check("sat_ffff", rd_count1, 16'hFFFF);
    repeat (4465) tick();
    check("sat_hold", rd_count1, 16'hFFFF);
    cpu_rd = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cvp14_mem_responder.md
Name: cvp14_mem_responder

Overview:
- Memory-side responder for the CVP14 core's bus. It accepts Addr/RD/WR/dataOut from the core and returns DataIn with a fixed, pipelined read latency.
- Backs instruction fetch, VLD/VST/SST and J-driven fetch streams with a single word-addressed 16-bit array.
- Provides a valid/ready preload port so a test harness can load programs and data while the core is held in reset.
- Keeps saturating access counters and sticky error and overflow status for verification.

Parameters:
DEPTH_LOG2, 12, array holds 2^DEPTH_LOG2 16-bit words at addresses 0..2^DEPTH_LOG2-1.
READ_LAT, 1, edges from RD sampled to rd_data updated; legal range 1..4. The core requires 1.
INIT_ZERO, 1, 1 = array contents are 0 at time zero (simulation init only; Reset never clears the array).

Ports:
Clk1  in  1  clock; all state updates on posedge.
Reset  in  1  synchronous, active-high.
cpu_addr  in  16  word address (core Addr).
cpu_rd  in  1  read request (core RD).
cpu_wr  in  1  write request (core WR).
cpu_wdata  in  16  write data (core dataOut).
cpu_v  in  1  core overflow flag V.
rd_data  out  16  read data to core (core DataIn).
rd_valid  out  1  one-cycle pulse when rd_data updates.
ld_valid  in  1  preload word valid.
ld_ready  out  1  preload accepted this cycle when high with ld_valid.
ld_addr  in  16  preload address.
ld_data  in  16  preload data.
rd_count  out  16  reads accepted, saturating at 16'hFFFF.
wr_count  out  16  writes accepted, saturating.
err_oob  out  1  sticky: access to address >= 2^DEPTH_LOG2.
err_rdwr  out  1  sticky: cpu_rd and cpu_wr high in the same cycle.
ovf_seen  out  1  sticky: cpu_v sampled high.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, rd_count=0, wr_count=0, err_oob=0, err_rdwr=0, ovf_seen=0, read pipeline all invalid. The array is NOT cleared.
- Reset mid-read: all in-flight reads are discarded. No rd_valid pulse occurs for them after Reset.
- CPU read:
  - cpu_rd=1 and cpu_wr=0 at edge N captures the address into pipeline stage 1.
  - The array is read at stage READ_LAT. rd_data and rd_valid update at edge N+READ_LAT.
  - rd_data holds its value until the next read completes.
  - Back-to-back reads, one per cycle, are fully pipelined: one result per cycle, in order. This covers the core's Load state, which consumes word k-1 while issuing address k.
- CPU write: cpu_wr=1 at edge N writes cpu_wdata to the array at edge N. There is no response and no rd_valid.
- Read-after-write: a read of address A captured at any edge after the write edge returns the new data.
  - With READ_LAT>1, a read already in flight whose array access happens after the write also returns the new data. The array is read at the final stage, not at capture.
- cpu_rd and cpu_wr both high: treated as a write only, no read is issued, and err_rdwr is set.
- Out of range (cpu_addr[15:DEPTH_LOG2] != 0):
  - A read returns 16'h0000 with a normal rd_valid pulse.
  - A write is dropped.
  - err_oob is set in both cases, and the access is still counted.
- Preload:
  - ld_ready = ~cpu_rd & ~cpu_wr. The core has priority; preload is also allowed while Reset is high.
  - Transfer occurs when ld_valid & ld_ready at an edge: ld_data is written to ld_addr.
  - An out-of-range ld_addr is dropped and sets err_oob.
  - Preload does not affect the counters.
- Counters: rd_count increments on each accepted read, wr_count on each accepted write (including rd+wr collisions). Both hold at 16'hFFFF.
- ovf_seen: set when cpu_v=1 at any edge with Reset=0. Cleared only by Reset.
- Sticky flags are cleared only by Reset.
- Read pipeline: READ_LAT stages, each holding {valid, addr}. Stages shift every cycle with no stall.
- Clocks: Clk2 is not used.

Test Plan:
- Preload with Reset=1: write 0x8123 to address 0x0000 and 0xABCD to 0x0001 -> ld_ready=1 on both transfers. After Reset drops, cpu_rd@addr 0 at edge N gives rd_data=0x8123 and rd_valid=1 at N+1; rd_count=1.
- Burst read 0x0010..0x0013 (preloaded 1,2,3,4) on consecutive cycles -> rd_data = 1,2,3,4 at edges N+1..N+4, with rd_valid high on 4 consecutive cycles.
- Write 0x3C00 to 0x0020, then read 0x0020 next cycle -> rd_data=0x3C00 and wr_count=1. Repeat with READ_LAT=3, issuing the read one cycle after the write -> rd_data=0x3C00 three edges after the read.
- cpu_rd=cpu_wr=1 at 0x0030 with data 0x0055 -> err_rdwr=1, no rd_valid, and a later read of 0x0030 returns 0x0055. Read of 0x1000 with DEPTH_LOG2=12 -> rd_data=0x0000, rd_valid=1, err_oob=1.
- Assert Reset one cycle after cpu_rd (READ_LAT=2) -> no rd_valid pulse, counters and flags 0, and previously written 0x3C00 at 0x0020 is still readable.
- Pulse cpu_v for one cycle -> ovf_seen=1 until Reset. Drive 70000 reads -> rd_count=0xFFFF.
